fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_pc_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Widths, FSM state encoding, NOP and default halt opcode.
package fetch_stage_pkg;

    localparam int INST_W = 26;
    localparam int PC_W   = 16;
    localparam int OP_W   = 6;

    localparam logic [INST_W-1:0] NOP_INST    = '0;
    localparam logic [OP_W-1:0]   HALT_OP_DEF = 6'h3F;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Next-fetch-address mux and fpc register.
// fpc always points one past the address issued to the ROM.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  state_t          i_state,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    output logic [PC_W-1:0] o_fpc
);

    logic [PC_W-1:0] r_fpc;
    logic [PC_W-1:0] w_fpc_nxt;

    always_comb begin
        w_fpc_nxt = r_fpc;
        unique case (i_state)
            BOOT: w_fpc_nxt = RESET_PC + 16'd1;
            RUN: begin
                if (i_branch_taken)
                    w_fpc_nxt = i_branch_target + 16'd1;
                else if (!i_stall)
                    w_fpc_nxt = r_fpc + 16'd1;
            end
            HALTED: w_fpc_nxt = r_fpc;
            default: w_fpc_nxt = r_fpc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_fpc <= RESET_PC;
        else
            r_fpc <= w_fpc_nxt;
    end

    assign o_fpc = r_fpc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous ROM and presents
// inst/pc_count to IF/ID, with stall, branch redirect and halt.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [INST_W-1:0] rom_q,
    output logic [PC_W-1:0]   rom_addr,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc_count,
    output logic              inst_valid,
    output logic              halted,
    output logic [PC_W-1:0]   fetch_count
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_ipc;
    logic            r_ivalid;
    logic            w_ivalid_nxt;
    logic [PC_W-1:0] r_fetch_count;
    logic [PC_W-1:0] w_fpc;
    logic [PC_W-1:0] w_rom_addr;
    logic            w_accept;
    logic            w_is_halt;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .i_state        (r_state),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .o_fpc          (w_fpc)
    );

    assign inst       = r_ivalid ? rom_q : NOP_INST;
    assign inst_valid = r_ivalid & ~branch_taken;
    assign pc_count   = r_ipc;
    assign halted     = (r_state == HALTED);
    assign w_accept   = inst_valid & ~stall;
    assign w_is_halt  = (inst[INST_W-1 -: OP_W] == HALT_OP);

    always_comb begin
        w_state_nxt  = r_state;
        w_rom_addr   = w_fpc;
        w_ivalid_nxt = r_ivalid;
        unique case (r_state)
            BOOT: begin
                w_rom_addr   = w_fpc;
                w_ivalid_nxt = 1'b1;
                w_state_nxt  = RUN;
            end
            RUN: begin
                if (branch_taken)
                    w_rom_addr = branch_target;
                else if (stall)
                    w_rom_addr = r_ipc;
                else
                    w_rom_addr = w_fpc;
                w_ivalid_nxt = 1'b1;
                if (w_accept && w_is_halt)
                    w_state_nxt = HALTED;
            end
            HALTED: begin
                w_rom_addr   = r_ipc;
                w_ivalid_nxt = 1'b0;
            end
            default: begin
                w_rom_addr   = w_fpc;
                w_ivalid_nxt = 1'b0;
                w_state_nxt  = BOOT;
            end
        endcase
    end

    assign rom_addr = w_rom_addr;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= BOOT;
        else
            r_state <= w_state_nxt;
    end

    // ipc mirrors the ROM address register so rom_q is always mem[ipc]
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ipc         <= RESET_PC;
            r_ivalid      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_ipc    <= w_rom_addr;
            r_ivalid <= w_ivalid_nxt;
            if (w_accept && (r_fetch_count != 16'hFFFF))
                r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;

endmodule
